ftoi_pipe: RTL and testbench

// - Pipelined FP32 -> signed INT32 converter (fcvt.w.s class op); the unpack/denormalise counterpart of the FP add path.
// - Sits beside the adder in the FPU; valid/ready on both sides so it can stall behind a busy writeback port.
// - Two register stages: stage 1 unpacks and aligns, stage 2 rounds, negates and saturates.

---
 rtl/fpu_pkg.sv | 25 ++
 rtl/fpu_rshift_round.sv | 28 ++
 rtl/ftoi_pipe.sv | 156 +++++++++++++++
 tb/tb_ftoi_pipe.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU types and constants for the FP32 -> INT32 conversion path.
package fpu_pkg;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
  } fp32_t;

  localparam logic [7:0]  FP_BIAS        = 8'd127;
  // Exponent at which the 24-bit mantissa is already an integer (no shift).
  localparam logic [7:0]  FTOI_EXP_EXACT = FP_BIAS + 8'd23;
  // Largest exponent whose value can still fit a signed 32-bit integer.
  localparam logic [7:0]  FTOI_EXP_MAX   = 8'd157;
  localparam logic [31:0] INT32_MAX      = 32'h7FFFFFFF;
  localparam logic [31:0] INT32_MIN      = 32'h80000000;
  // -2^31 is the only exponent-158 value that is representable.
  localparam logic [31:0] FP32_NEG_2P31  = 32'hCF000000;

  // Mantissa with the hidden bit; exponent zero flushes denormals (no hidden bit).
  function automatic logic [23:0] fp32_mant(input fp32_t f);
    return {|f.e, f.m};
  endfunction

endpackage

// File: rtl/fpu_rshift_round.sv
// Right shift of a 24-bit mantissa returning the kept bits, the first bit
// shifted out (round bit) and the OR of every bit shifted out (sticky).
// Shifts of 25 or more discard the whole mantissa.
module fpu_rshift_round (
  input  logic [23:0] mant,
  input  logic [4:0]  sh,
  output logic [23:0] q,
  output logic        rbit,
  output logic        sticky
);

  logic [47:0] wide;

  // Shift into a double-width word so the discarded bits land in the low half.
  always_comb begin
    wide = {mant, 24'd0} >> sh;
    if (sh >= 5'd25) begin
      q      = '0;
      rbit   = 1'b0;
      sticky = |mant;
    end else begin
      q      = wide[47:24];
      rbit   = wide[23];
      sticky = |wide[23:0];
    end
  end

endmodule

// File: rtl/ftoi_pipe.sv
// Two-stage pipelined FP32 -> signed INT32 converter with valid/ready on both
// sides. Stage 1 unpacks, classifies and aligns; stage 2 rounds, negates and
// saturates. Optional FTOI_FLAGS_EN adds registered out_nv / out_nx flags.
module ftoi_pipe
  import fpu_pkg::*;
#(
  parameter int ROUND = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y
`ifdef FTOI_FLAGS_EN
  ,
  output logic        out_nv,
  output logic        out_nx
`endif
);

  fp32_t       xf;
  logic [23:0] mant;
  logic        is_nan, is_ovf, is_zero, is_left;
  logic [3:0]  lsh;
  logic [7:0]  rsh_full;
  logic [4:0]  rsh;
  logic [23:0] rs_q;
  logic        rs_rbit, rs_sticky;
  logic [31:0] mag_next;
  logic        rbit_next;
  logic        adv1, adv2;

  logic        v1_reg, v2_reg;
  logic        s1_sign_reg, s1_nan_reg, s1_ovf_reg, s1_zero_reg, s1_rbit_reg;
  logic [31:0] s1_mag_reg;
  logic [31:0] mag_rnd, y_next, y_reg;

  assign adv2      = !v2_reg || out_ready;
  assign adv1      = !v1_reg || adv2;
  assign in_ready  = adv1;
  assign out_valid = v2_reg;
  assign y         = y_reg;

  assign xf       = x;
  assign mant     = fp32_mant(xf);
  assign is_nan   = (&xf.e) && (|xf.m);
  assign is_ovf   = (xf.e > FTOI_EXP_MAX) && (x != FP32_NEG_2P31) && !is_nan;
  assign is_zero  = (x[30:0] == 31'd0);
  assign is_left  = (xf.e >= FTOI_EXP_EXACT);
  // Only exponents 150..158 reach the left path without saturating: 0..8 bits.
  assign lsh      = 4'(xf.e - FTOI_EXP_EXACT);
  assign rsh_full = FTOI_EXP_EXACT - xf.e;
  assign rsh      = (rsh_full > 8'd31) ? 5'd31 : rsh_full[4:0];

  fpu_rshift_round u_rshift (
    .mant   (mant),
    .sh     (rsh),
    .q      (rs_q),
    .rbit   (rs_rbit),
    .sticky (rs_sticky)
  );

  // Pick the left- or right-aligned magnitude for the stage-1 register.
  always_comb begin
    mag_next  = {8'd0, rs_q};
    rbit_next = rs_rbit;
    if (is_left) begin
      mag_next  = {8'd0, mant} << lsh;
      rbit_next = 1'b0;
    end
  end

  // Stage 1: capture sign, class and aligned magnitude of the accepted operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg      <= 1'b0;
      s1_sign_reg <= 1'b0;
      s1_nan_reg  <= 1'b0;
      s1_ovf_reg  <= 1'b0;
      s1_zero_reg <= 1'b0;
      s1_rbit_reg <= 1'b0;
      s1_mag_reg  <= '0;
    end else if (adv1) begin
      v1_reg <= in_valid;
      if (in_valid) begin
        s1_sign_reg <= xf.s;
        s1_nan_reg  <= is_nan;
        s1_ovf_reg  <= is_ovf;
        s1_zero_reg <= is_zero;
        s1_rbit_reg <= rbit_next;
        s1_mag_reg  <= mag_next;
      end
    end
  end

  // Round, then either saturate or apply the sign in two's complement.
  always_comb begin
    mag_rnd = s1_mag_reg + {31'd0, (ROUND != 0) && s1_rbit_reg};
    y_next  = s1_sign_reg ? (32'd0 - mag_rnd) : mag_rnd;
    if (s1_nan_reg) begin
      y_next = INT32_MAX;
    end else if (s1_ovf_reg) begin
      y_next = s1_sign_reg ? INT32_MIN : INT32_MAX;
    end else if (s1_zero_reg) begin
      y_next = '0;
    end
  end

  // Stage 2: output register, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_reg <= 1'b0;
      y_reg  <= '0;
    end else if (adv2) begin
      v2_reg <= v1_reg;
      if (v1_reg) begin
        y_reg <= y_next;
      end
    end
  end

`ifdef FTOI_FLAGS_EN
  logic s1_sticky_reg, nv_reg, nx_reg;

  // Sticky travels with the stage-1 payload so nx lines up with y.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sticky_reg <= 1'b0;
    end else if (adv1 && in_valid) begin
      s1_sticky_reg <= is_left ? 1'b0 : rs_sticky;
    end
  end

  // Flags register alongside y; saturated results never report inexact.
  always_ff @(posedge clk) begin
    if (rst) begin
      nv_reg <= 1'b0;
      nx_reg <= 1'b0;
    end else if (adv2 && v1_reg) begin
      nv_reg <= s1_nan_reg || s1_ovf_reg;
      nx_reg <= s1_sticky_reg && !s1_nan_reg && !s1_ovf_reg && !s1_zero_reg;
    end
  end

  assign out_nv = nv_reg;
  assign out_nx = nx_reg;
`else
  // Sticky only feeds the inexact flag, which this build does not have.
  logic unused_sticky;
  assign unused_sticky = rs_sticky;
`endif

endmodule

// File: tb/tb_ftoi_pipe.sv
// Self-checking bench for ftoi_pipe: directed corner values with literal
// expectations, randomized operands against an arithmetic reference model,
// stall/backpressure, back-to-back latency and mid-stream reset.
module tb_ftoi_pipe;

  localparam int ROUND = 1;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [31:0] x;
  wire         in_ready, out_valid;
  wire  [31:0] y;
`ifdef FTOI_FLAGS_EN
  wire         out_nv, out_nx;
`endif

  ftoi_pipe #(.ROUND(ROUND)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
`ifdef FTOI_FLAGS_EN
    ,
    .out_nv    (out_nv),
    .out_nx    (out_nx)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        nv;
    logic        nx;
    int          cyc;
  } exp_t;

  exp_t pend[$];
  exp_t sb[$];
  exp_t ent;
  int   checks = 0;
  int   errors = 0;
  int   ncyc   = 0;
  int   n_acc  = 0;
  bit   chk_lat = 1'b0;

  // Directed corners with literal expectations (ROUND = 1).
  logic [31:0] dir_x  [12] = '{32'h3F800000, 32'h40200000, 32'hC0200000, 32'h3F000000,
                               32'h3EFFFFFF, 32'h4F000000, 32'hCF000000, 32'h7FC00000,
                               32'hFF800000, 32'h80000000, 32'h00000001, 32'h4EFFFFFF};
  logic [31:0] dir_y  [12] = '{32'h00000001, 32'h00000003, 32'hFFFFFFFD, 32'h00000001,
                               32'h00000000, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF,
                               32'h80000000, 32'h00000000, 32'h00000000, 32'h7FFFFF80};
  logic        dir_nv [12] = '{0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0};
  logic        dir_nx [12] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0};

  // Reference: value = mant * 2^(e-150), rounded by integer division/remainder.
  function automatic exp_t model(input logic [31:0] v);
    exp_t   r;
    longint mant, mag, lim, den, qt, rem;
    int     e, k;
    bit     s;
    s    = v[31];
    e    = int'(v[30:23]);
    mant = longint'(v[22:0]);
    if (e != 0) mant = mant + 64'sd8388608;
    r.x = v; r.y = 32'd0; r.nv = 1'b0; r.nx = 1'b0; r.cyc = 0;
    if (e == 255 && v[22:0] != 23'd0) begin
      r.y = 32'h7FFFFFFF; r.nv = 1'b1;
    end else if (e >= 190) begin
      r.y = s ? 32'h80000000 : 32'h7FFFFFFF; r.nv = 1'b1;
    end else begin
      if (e >= 150) begin
        mag = mant <<< (e - 150);
      end else begin
        k = 150 - e;
        if (k >= 40) begin
          mag = 0;
          r.nx = (mant != 0);
        end else begin
          den  = 64'sd1 <<< k;
          qt   = mant / den;
          rem  = mant % den;
          r.nx = (rem != 0);
          mag  = qt + ((ROUND != 0 && 2 * rem >= den) ? 64'sd1 : 64'sd0);
        end
      end
      lim = s ? 64'sd2147483648 : 64'sd2147483647;
      if (mag > lim) begin
        r.y = s ? 32'h80000000 : 32'h7FFFFFFF; r.nv = 1'b1; r.nx = 1'b0;
      end else begin
        r.y = 32'(s ? -mag : mag);
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rnd_x();
    logic [31:0] v;
    int          sel;
    v   = $urandom;
    sel = $urandom_range(0, 7);
    if (sel < 5)       v[30:23] = 8'($urandom_range(120, 160));
    else if (sel == 5) v[30:23] = 8'($urandom_range(0, 1)) * 8'd255;
    else if (sel == 6) v = {v[31], 8'd158, 23'd0};
    return v;
  endfunction

  // Monitor/scoreboard: check consumed outputs, log accepted inputs.
  always @(negedge clk) begin
    ncyc++;
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        assert (sb.size() > 0) else begin
          errors++; $error("FAIL spurious_out y=%h expected no output", y);
        end
        if (sb.size() > 0) begin
          ent = sb.pop_front();
          checks++;
          assert (y === ent.y) else begin
            errors++; $error("FAIL y x=%h got=%h exp=%h", ent.x, y, ent.y);
          end
`ifdef FTOI_FLAGS_EN
          checks++;
          assert ({out_nv, out_nx} === {ent.nv, ent.nx}) else begin
            errors++; $error("FAIL flags x=%h got nv=%b nx=%b exp nv=%b nx=%b",
                             ent.x, out_nv, out_nx, ent.nv, ent.nx);
          end
`endif
          if (chk_lat) begin
            checks++;
            assert (ncyc - ent.cyc == 2) else begin
              errors++; $error("FAIL latency x=%h got=%0d exp=2", ent.x, ncyc - ent.cyc);
            end
          end
          $display("OUT x=%h y=%h cyc=%0d", ent.x, y, ncyc);
        end
      end
      if (in_valid && in_ready && pend.size() > 0) begin
        ent     = pend.pop_front();
        ent.cyc = ncyc;
        sb.push_back(ent);
        n_acc++;
      end
    end
  end

  task automatic wait_acc(input int cnt, input string tag);
    int i = 0;
    while (n_acc == cnt && i < 200) begin
      @(posedge clk);
      i++;
    end
    #1;
    checks++;
    assert (n_acc != cnt) else begin
      errors++; $error("FAIL %s accept_timeout n_acc=%0d exp>%0d", tag, n_acc, cnt);
    end
  endtask

  task automatic send(input exp_t e_in);
    int cnt;
    pend.push_back(e_in);
    x        = e_in.x;
    in_valid = 1'b1;
    cnt      = n_acc;
    wait_acc(cnt, "send");
  endtask

  task automatic drain();
    int i = 0;
    in_valid = 1'b0;
    while ((sb.size() != 0 || out_valid) && i < 100) begin
      @(negedge clk);
      i++;
    end
    checks++;
    assert (sb.size() == 0 && !out_valid) else begin
      errors++; $error("FAIL drain_timeout left=%0d exp=0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t        ev;
    logic [31:0] y_hold;
    int          acc0, cnt;
    bit          have;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; assert (out_valid === 1'b0) else begin errors++; $error("FAIL rst_valid got=%b exp=0", out_valid); end
    checks++; assert (y === 32'd0)        else begin errors++; $error("FAIL rst_y got=%h exp=0", y); end
    checks++; assert (in_ready === 1'b1)  else begin errors++; $error("FAIL rst_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;

    // Directed corners, streamed back to back.
    for (int i = 0; i < 12; i++) begin
      ev = '{x: dir_x[i], y: dir_y[i], nv: dir_nv[i], nx: dir_nx[i], cyc: 0};
      send(ev);
    end
    drain();

    // Eight consecutive inputs: each must emerge exactly 2 cycles later.
    chk_lat = 1'b1;
    for (int i = 0; i < 8; i++) send(model(rnd_x()));
    drain();
    chk_lat = 1'b0;

    // Backpressure: out_ready low for 4 cycles with in_valid held.
    out_ready = 1'b0;
    acc0 = n_acc;
    send(model(rnd_x()));
    send(model(rnd_x()));
    ev = model(rnd_x());
    pend.push_back(ev); x = ev.x; in_valid = 1'b1;
    @(negedge clk);
    y_hold = y;
    checks++; assert (out_valid === 1'b1) else begin errors++; $error("FAIL stall_valid got=%b exp=1", out_valid); end
    checks++; assert (in_ready === 1'b0)  else begin errors++; $error("FAIL stall_ready got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; assert (y === y_hold)       else begin errors++; $error("FAIL stall_y got=%h exp=%h", y, y_hold); end
    checks++; assert (in_ready === 1'b0)  else begin errors++; $error("FAIL stall_ready2 got=%b exp=0", in_ready); end
    checks++; assert (n_acc - acc0 == 2)  else begin errors++; $error("FAIL stall_accepts got=%0d exp=2", n_acc - acc0); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_acc(acc0 + 2, "release");
    drain();

    // Randomized traffic with random consumer stalls.
    have = 1'b0; cnt = 0;
    for (int i = 0; i < 400; i++) begin
      if (!have && $urandom_range(0, 3) != 0) begin
        ev = model(rnd_x());
        pend.push_back(ev); x = ev.x; in_valid = 1'b1;
        have = 1'b1; cnt = n_acc;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      if (have && n_acc != cnt) begin have = 1'b0; in_valid = 1'b0; end
    end
    out_ready = 1'b1;
    if (have) wait_acc(cnt, "rand_tail");
    drain();

    // Reset mid-stream: in-flight results must vanish.
    for (int i = 0; i < 3; i++) send(model(rnd_x()));
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; assert (out_valid === 1'b0) else begin errors++; $error("FAIL midrst_valid got=%b exp=0", out_valid); end
    checks++; assert (in_ready === 1'b1)  else begin errors++; $error("FAIL midrst_ready got=%b exp=1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; assert (out_valid === 1'b0) else begin errors++; $error("FAIL midrst_stale got=%b exp=0", out_valid); end
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send(model(rnd_x()));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
